// File: rtl/countdown_timer_if.sv
// Control and count bus of the minutes:seconds countdown timer.
// The master drives the controls and presets; the slave is the timer.
interface countdown_timer_if #(
   parameter int unsigned MIN_WIDTH = 7,
   parameter int unsigned SEC_WIDTH = 6
);
   logic                 i_tick;
   logic                 i_load;
   logic [MIN_WIDTH-1:0] i_load_min;
   logic [SEC_WIDTH-1:0] i_load_sec;
   logic                 i_start;
   logic                 i_pause;
   logic                 i_clear;
   logic [MIN_WIDTH-1:0] o_min;
   logic [SEC_WIDTH-1:0] o_sec;
   logic                 o_running;
   logic                 o_expired;
   logic                 o_borrow;
   logic                 o_done;

   modport master (
      output i_tick, i_load, i_load_min, i_load_sec, i_start, i_pause, i_clear,
      input  o_min, o_sec, o_running, o_expired, o_borrow, o_done
   );

   modport slave (
      input  i_tick, i_load, i_load_min, i_load_sec, i_start, i_pause, i_clear,
      output o_min, o_sec, o_running, o_expired, o_borrow, o_done
   );
endinterface

// File: rtl/countdown_timer.sv
// Loadable minutes:seconds down-counter with a seconds->minutes borrow chain
// and an IDLE/RUN/PAUSED/EXPIRED control machine; all outputs registered.
module countdown_timer #(
   parameter int unsigned SEC_WIDTH = 6,
   parameter int unsigned MIN_WIDTH = 7,
   parameter int unsigned SEC_MAX   = 60,
   parameter int unsigned MIN_MAX   = 100
) (
   input logic              i_sysclk,
   input logic              i_reset,
   countdown_timer_if.slave bus
);

   localparam logic [SEC_WIDTH-1:0] SEC_TOP = SEC_WIDTH'(SEC_MAX - 1);
   localparam logic [MIN_WIDTH-1:0] MIN_TOP = MIN_WIDTH'(MIN_MAX - 1);
   localparam logic [SEC_WIDTH-1:0] SEC_ONE = SEC_WIDTH'(1);
   localparam logic [MIN_WIDTH-1:0] MIN_ONE = MIN_WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      PAUSED  = 2'd2,
      EXPIRED = 2'd3
   } state_t;

   state_t               state_q,   state_d;
   logic [MIN_WIDTH-1:0] min_q,     min_d;
   logic [SEC_WIDTH-1:0] sec_q,     sec_d;
   logic                 running_q, running_d;
   logic                 expired_q, expired_d;
   logic                 borrow_q,  borrow_d;
   logic                 done_q,    done_d;

   // Next state / count; controls are resolved in strict priority order.
   always_comb begin
      state_d  = state_q;
      min_d    = min_q;
      sec_d    = sec_q;
      borrow_d = 1'b0;
      done_d   = 1'b0;

      if (bus.i_clear) begin
         min_d   = '0;
         sec_d   = '0;
         state_d = IDLE;
      end else if (bus.i_load) begin
         min_d   = (bus.i_load_min > MIN_TOP) ? MIN_TOP : bus.i_load_min;
         sec_d   = (bus.i_load_sec > SEC_TOP) ? SEC_TOP : bus.i_load_sec;
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (!bus.i_pause && bus.i_start && (min_q != '0 || sec_q != '0))
                  state_d = RUN;
            end
            RUN: begin
               if (bus.i_pause) begin
                  state_d = PAUSED;
               end else if (!bus.i_start && bus.i_tick) begin
                  if (sec_q != '0) begin
                     sec_d = sec_q - SEC_ONE;
                     // 00:01 -> 00:00 expires on the same edge as the decrement
                     if (min_q == '0 && sec_q == SEC_ONE) begin
                        state_d = EXPIRED;
                        done_d  = 1'b1;
                     end
                  end else if (min_q != '0) begin
                     sec_d    = SEC_TOP;
                     min_d    = min_q - MIN_ONE;
                     borrow_d = 1'b1;
                  end
               end
            end
            PAUSED: begin
               if (!bus.i_pause && bus.i_start)
                  state_d = RUN;
            end
            default: ;
         endcase
      end

      running_d = (state_d == RUN);
      expired_d = (state_d == EXPIRED);
   end

   always_ff @(posedge i_sysclk or posedge i_reset) begin
      if (i_reset) begin
         state_q   <= IDLE;
         min_q     <= '0;
         sec_q     <= '0;
         running_q <= 1'b0;
         expired_q <= 1'b0;
         borrow_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         min_q     <= min_d;
         sec_q     <= sec_d;
         running_q <= running_d;
         expired_q <= expired_d;
         borrow_q  <= borrow_d;
         done_q    <= done_d;
      end
   end

   assign bus.o_min     = min_q;
   assign bus.o_sec     = sec_q;
   assign bus.o_running = running_q;
   assign bus.o_expired = expired_q;
   assign bus.o_borrow  = borrow_q;
   assign bus.o_done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios plus random control traffic,
// compared every cycle against a total-seconds reference model.
module tb_countdown_timer;

   localparam int unsigned MIN_WIDTH = 7;
   localparam int unsigned SEC_WIDTH = 6;

   localparam int M_IDLE    = 0;
   localparam int M_RUN     = 1;
   localparam int M_PAUSED  = 2;
   localparam int M_EXPIRED = 3;

   logic clk;
   logic rst;

   countdown_timer_if #(.MIN_WIDTH(MIN_WIDTH), .SEC_WIDTH(SEC_WIDTH)) bus ();

   countdown_timer #(
      .SEC_WIDTH(SEC_WIDTH),
      .MIN_WIDTH(MIN_WIDTH),
      .SEC_MAX  (60),
      .MIN_MAX  (100)
   ) dut (
      .i_sysclk(clk),
      .i_reset (rst),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: remaining time as a plain count of seconds.
   int m_total;
   int m_mode;
   int m_borrow;
   int m_done;
   int n_done_seen = 0;
   int n_borrow_seen = 0;

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      m_total  = 0;
      m_mode   = M_IDLE;
      m_borrow = 0;
      m_done   = 0;
   endtask

   task automatic model_step(input bit clr, input bit ld, input int lm, input int ls,
                             input bit ps, input bit st, input bit tk);
      m_borrow = 0;
      m_done   = 0;
      if (clr) begin
         m_total = 0;
         m_mode  = M_IDLE;
      end else if (ld) begin
         m_total = ((lm > 99) ? 99 : lm) * 60 + ((ls > 59) ? 59 : ls);
         m_mode  = M_IDLE;
      end else if (ps) begin
         if (m_mode == M_RUN) m_mode = M_PAUSED;
      end else if (st) begin
         if ((m_mode == M_IDLE && m_total > 0) || m_mode == M_PAUSED) m_mode = M_RUN;
      end else if (tk && m_mode == M_RUN && m_total > 0) begin
         if (m_total % 60 == 0) m_borrow = 1;
         m_total--;
         if (m_total == 0) begin
            m_mode = M_EXPIRED;
            m_done = 1;
         end
      end
   endtask

   task automatic check_model(input string where);
      check({where, ".min"},     bus.o_min,     m_total / 60);
      check({where, ".sec"},     bus.o_sec,     m_total % 60);
      check({where, ".running"}, bus.o_running, (m_mode == M_RUN)     ? 1 : 0);
      check({where, ".expired"}, bus.o_expired, (m_mode == M_EXPIRED) ? 1 : 0);
      check({where, ".borrow"},  bus.o_borrow,  m_borrow);
      check({where, ".done"},    bus.o_done,    m_done);
      if (bus.o_done === 1'b1) n_done_seen++;
      if (bus.o_borrow === 1'b1) n_borrow_seen++;
   endtask

   // One clock: drive controls, take the edge, advance the model, compare.
   task automatic step(input string where, input bit clr, input bit ld, input int lm,
                       input int ls, input bit ps, input bit st, input bit tk);
      bus.i_clear    = clr;
      bus.i_load     = ld;
      bus.i_load_min = MIN_WIDTH'(lm);
      bus.i_load_sec = SEC_WIDTH'(ls);
      bus.i_pause    = ps;
      bus.i_start    = st;
      bus.i_tick     = tk;
      @(posedge clk);
      model_step(clr, ld, lm, ls, ps, st, tk);
      #1;
      check_model(where);
   endtask

   task automatic do_load(input string w, input int lm, input int ls);
      step(w, 0, 1, lm, ls, 0, 0, 0);
   endtask
   task automatic do_start(input string w);
      step(w, 0, 0, 0, 0, 0, 1, 0);
   endtask
   task automatic do_tick(input string w);
      step(w, 0, 0, 0, 0, 0, 0, 1);
   endtask
   task automatic do_pause(input string w);
      step(w, 0, 0, 0, 0, 1, 0, 0);
   endtask
   task automatic do_idle(input string w);
      step(w, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      bus.i_tick = 0; bus.i_load = 0; bus.i_load_min = '0; bus.i_load_sec = '0;
      bus.i_start = 0; bus.i_pause = 0; bus.i_clear = 0;
      model_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_model("reset");
      rst = 1'b0;
      do_idle("post_reset");

      // Async reset while running: outputs clear between clock edges.
      do_load("rst_ld", 1, 2);
      do_start("rst_st");
      do_tick("rst_tk");
      check("rst_pre_running", bus.o_running, 1);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check("rst_async_min", bus.o_min, 0);
      check("rst_async_sec", bus.o_sec, 0);
      check("rst_async_running", bus.o_running, 0);
      check("rst_async_expired", bus.o_expired, 0);
      @(negedge clk);
      rst = 1'b0;
      do_idle("rst_rel");

      // Borrow across the minute boundary.
      do_load("b_ld", 1, 2);
      do_start("b_st");
      do_tick("b_t1");
      do_tick("b_t2");
      check("b_no_borrow_yet", bus.o_borrow, 0);
      do_tick("b_t3");
      check("b_min_after3", bus.o_min, 0);
      check("b_sec_after3", bus.o_sec, 59);
      check("b_borrow_after3", bus.o_borrow, 1);
      do_idle("b_hold");
      check("b_borrow_one_cycle", bus.o_borrow, 0);

      // Expiry: done pulses once, expired holds, further ticks ignored.
      do_load("e_ld", 0, 2);
      do_start("e_st");
      do_tick("e_t1");
      do_tick("e_t2");
      check("e_done", bus.o_done, 1);
      check("e_expired", bus.o_expired, 1);
      check("e_borrow_final", bus.o_borrow, 0);
      do_tick("e_t3");
      check("e_done_once", bus.o_done, 0);
      check("e_expired_level", bus.o_expired, 1);
      do_start("e_start_noeffect");
      do_tick("e_t4");
      check("e_sec_held", bus.o_sec, 0);

      // Pause holds the count; resume continues.
      do_load("p_ld", 0, 10);
      do_start("p_st");
      do_tick("p_t1");
      do_tick("p_t2");
      step("p_pause_tick", 0, 0, 0, 0, 1, 0, 1);
      check("p_running_low", bus.o_running, 0);
      for (int i = 0; i < 5; i++) do_tick("p_ign");
      do_pause("p_pause2");
      do_start("p_resume");
      do_tick("p_t3");
      check("p_sec_final", bus.o_sec, 7);

      // Tick coincident with start is not counted.
      do_load("c_ld", 0, 5);
      step("c_st_tick", 0, 0, 0, 0, 0, 1, 1);
      check("c_sec_unchanged", bus.o_sec, 5);
      do_tick("c_t1");
      check("c_sec_next", bus.o_sec, 4);

      // Load saturation; start from 00:00 does nothing.
      do_load("s_ld", 120, 63);
      check("s_min_sat", bus.o_min, 99);
      check("s_sec_sat", bus.o_sec, 59);
      step("s_clear", 1, 0, 0, 0, 0, 0, 0);
      do_start("s_start_zero");
      check("s_zero_running", bus.o_running, 0);
      check("s_zero_done", bus.o_done, 0);

      // Load+start while running -> IDLE with new value; clear beats load.
      do_load("l_ld", 5, 0);
      do_start("l_st");
      do_tick("l_t1");
      step("l_ld_st", 0, 1, 0, 30, 0, 1, 0);
      check("l_running_low", bus.o_running, 0);
      check("l_sec_new", bus.o_sec, 30);
      step("l_clr_ld", 1, 1, 3, 3, 0, 0, 0);
      check("l_clear_wins", bus.o_sec, 0);

      // Random control traffic.
      for (int i = 0; i < 4000; i++) begin
         int r;
         int lm;
         int ls;
         r  = int'($urandom_range(0, 999));
         lm = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 127))
                                          : int'($urandom_range(0, 1));
         ls = int'($urandom_range(0, 63));
         step("rnd", r < 5, r >= 5 && r < 15, lm, ls, r >= 15 && r < 30,
              r >= 30 && r < 90, $urandom_range(0, 2) == 0);
      end
      check("rnd_saw_done", (n_done_seen > 1) ? 1 : 0, 1);
      check("rnd_saw_borrow", (n_borrow_seen > 1) ? 1 : 0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
